skin_mask_ctrl: RTL and testbench

Frame-sequenced skin-detection controller that sits directly after the RGB-to-YCbCr converter in the gesture pipeline. It holds host-programmable Cb/Cr threshold windows, commits them to the datapath only at frame start, and tracks pixel coordinates of the converter output stream. It emits a registered per-pixel skin mask with x/y tags, and a per-frame skin-pixel count with a short-frame error flag for the downstream gesture/centroid logic.

---
 rtl/skin_mask_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_skin_mask_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/skin_mask_ctrl.sv
// skin_mask_ctrl
//
// Skin-detection controller placed after the RGB-to-YCbCr converter.
// It holds host-programmable Cb/Cr threshold windows (shadow copy written by
// the host, active copy used by the comparator and refreshed only at frame
// start). It also tags each accepted pixel with its x/y position and counts
// skin pixels per frame for the downstream gesture/centroid logic.
//
// Ports
//   clk, rst            pixel clock, asynchronous active-high reset
//   cfg_we_i            config write strobe
//   cfg_addr_i          0=cb_min 1=cb_max 2=cr_min 3=cr_max
//   cfg_wdata_i         config write data
//   cfg_pending_o       shadow holds a write not yet committed
//   ycbcr_vsync_i       frame sync, a high pulse precedes each frame
//   ycbcr_clken_i       converter clock enable
//   ycbcr_valid_i       converter data valid
//   ycbcr_data_i        {Y, Cb, Cr}
//   mask_vsync_o        vsync delayed to line up with the mask outputs
//   mask_valid_o        mask_bit_o / mask_x_o / mask_y_o are valid
//   mask_bit_o          1 = skin pixel
//   mask_x_o, mask_y_o  position of the tagged pixel
//   frame_skin_cnt_o    skin pixels in the last closed frame
//   frame_done_o        one-cycle pulse when a frame closes
//   frame_err_o         qualified by frame_done_o, 1 = frame closed short
module skin_mask_ctrl #(
  parameter int H_ACT = 640,
  parameter int V_ACT = 480,
  parameter int CNT_W = 19
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we_i,
  input  logic [1:0]       cfg_addr_i,
  input  logic [7:0]       cfg_wdata_i,
  output logic             cfg_pending_o,
  input  logic             ycbcr_vsync_i,
  input  logic             ycbcr_clken_i,
  input  logic             ycbcr_valid_i,
  input  logic [23:0]      ycbcr_data_i,
  output logic             mask_vsync_o,
  output logic             mask_valid_o,
  output logic             mask_bit_o,
  output logic [9:0]       mask_x_o,
  output logic [9:0]       mask_y_o,
  output logic [CNT_W-1:0] frame_skin_cnt_o,
  output logic             frame_done_o,
  output logic             frame_err_o
);

  typedef enum logic [1:0] {WAIT_SOF, ACTIVE, CLOSE} state_t;

  // Threshold registers packed with index 0 = cb_min ... index 3 = cr_max.
  localparam logic [3:0][7:0] THR_RST = {8'd173, 8'd133, 8'd127, 8'd77};
  localparam logic [9:0]      X_LAST  = 10'(H_ACT - 1);
  localparam logic [9:0]      Y_LAST  = 10'(V_ACT - 1);

  state_t           state_q, state_d;
  logic [3:0][7:0]  shadow_q, active_q;
  logic             pending_q, pending_d;
  logic             vsync_q;
  logic [9:0]       x_q, x_d, y_q, y_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_acc;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;
  logic             done_q, done_d, err_q, err_d;
  logic             mvalid_q, mbit_q;
  logic [9:0]       mx_q, my_q;
  logic             tag;
  logic [9:0]       tag_x, tag_y;
  logic             sof, acc, hit;
  logic [7:0]       cb, cr;

  assign acc = ycbcr_clken_i & ycbcr_valid_i;
  assign sof = ycbcr_vsync_i & ~vsync_q;
  assign cb  = ycbcr_data_i[15:8];
  assign cr  = ycbcr_data_i[7:0];

  // Inclusive window test; when min > max no value can satisfy both bounds,
  // so an inverted window naturally yields 0.
  assign hit = (cb >= active_q[0]) && (cb <= active_q[1]) &&
               (cr >= active_q[2]) && (cr <= active_q[3]);

  // Saturating count including the current pixel's verdict.
  assign cnt_acc = (hit && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;

  // A write coinciding with SOF wins so it survives to the next commit.
  always_comb begin
    pending_d = pending_q;
    if (cfg_we_i) begin
      pending_d = 1'b1;
    end else if (sof) begin
      pending_d = 1'b0;
    end
  end

  // Shadow/active threshold storage; the commit copies the pre-write shadow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q  <= THR_RST;
      active_q  <= THR_RST;
      pending_q <= 1'b0;
      vsync_q   <= 1'b0;
    end else begin
      if (sof) active_q <= shadow_q;
      if (cfg_we_i) shadow_q[cfg_addr_i] <= cfg_wdata_i;
      pending_q <= pending_d;
      vsync_q   <= ycbcr_vsync_i;
    end
  end

  // Frame sequencing, pixel tagging and skin counting.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    fcnt_d  = fcnt_q;
    done_d  = 1'b0;
    err_d   = err_q;
    tag     = 1'b0;
    tag_x   = x_q;
    tag_y   = y_q;
    case (state_q)
      WAIT_SOF, CLOSE: begin
        if (state_q == CLOSE) state_d = WAIT_SOF;
        if (sof) begin
          x_d     = '0;
          y_d     = '0;
          cnt_d   = '0;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (sof) begin
          // Short frame: report the partial count, restart at the origin.
          fcnt_d = cnt_q;
          done_d = 1'b1;
          err_d  = 1'b1;
          x_d    = '0;
          y_d    = '0;
          cnt_d  = '0;
          if (acc) begin
            tag   = 1'b1;
            tag_x = '0;
            tag_y = '0;
            x_d   = 10'd1;
            cnt_d = {{(CNT_W-1){1'b0}}, hit};
          end
        end else if (acc) begin
          tag   = 1'b1;
          cnt_d = cnt_acc;
          if (x_q == X_LAST) begin
            x_d = '0;
            if (y_q == Y_LAST) begin
              y_d     = '0;
              fcnt_d  = cnt_acc;
              done_d  = 1'b1;
              err_d   = 1'b0;
              state_d = CLOSE;
            end else begin
              y_d = y_q + 10'd1;
            end
          end else begin
            x_d = x_q + 10'd1;
          end
        end
      end
      default: state_d = WAIT_SOF;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= WAIT_SOF;
      x_q      <= '0;
      y_q      <= '0;
      cnt_q    <= '0;
      fcnt_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      mvalid_q <= 1'b0;
      mbit_q   <= 1'b0;
      mx_q     <= '0;
      my_q     <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      cnt_q    <= cnt_d;
      fcnt_q   <= fcnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      mvalid_q <= tag;
      mbit_q   <= tag & hit;
      if (tag) begin
        mx_q <= tag_x;
        my_q <= tag_y;
      end
    end
  end

  assign cfg_pending_o    = pending_q;
  assign mask_vsync_o     = vsync_q;
  assign mask_valid_o     = mvalid_q;
  assign mask_bit_o       = mbit_q;
  assign mask_x_o         = mx_q;
  assign mask_y_o         = my_q;
  assign frame_skin_cnt_o = fcnt_q;
  assign frame_done_o     = done_q;
  assign frame_err_o      = err_q;

endmodule

// File: tb/tb_skin_mask_ctrl.sv
// tb_skin_mask_ctrl
//
// Directed bench for skin_mask_ctrl, using a reduced 40x30 frame so the
// full-frame and short-frame sequences stay short. Inputs change 1 time unit
// after a rising edge; outputs are sampled 1 time unit after the next edge,
// where the one-cycle registered results are already visible.
module tb_skin_mask_ctrl;
  localparam int H  = 40;
  localparam int V  = 30;
  localparam int CW = 11;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_we;
  logic [1:0]    cfg_addr;
  logic [7:0]    cfg_wdata;
  logic          cfg_pending;
  logic          vsync, clken, valid;
  logic [23:0]   data;
  logic          mask_vsync, mask_valid, mask_bit;
  logic [9:0]    mask_x, mask_y;
  logic [CW-1:0] fcnt;
  logic          done, err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  skin_mask_ctrl #(.H_ACT(H), .V_ACT(V), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr), .cfg_wdata_i(cfg_wdata),
    .cfg_pending_o(cfg_pending),
    .ycbcr_vsync_i(vsync), .ycbcr_clken_i(clken), .ycbcr_valid_i(valid),
    .ycbcr_data_i(data),
    .mask_vsync_o(mask_vsync), .mask_valid_o(mask_valid), .mask_bit_o(mask_bit),
    .mask_x_o(mask_x), .mask_y_o(mask_y),
    .frame_skin_cnt_o(fcnt), .frame_done_o(done), .frame_err_o(err)
  );

  // Drive one cycle of converter input and wait until just after the edge.
  task automatic applyStimulus(input logic vs, input logic ce, input logic dv,
                               input logic [7:0] cb, input logic [7:0] cr);
    vsync = vs;
    clken = ce;
    valid = dv;
    data  = {8'd128, cb, cr};
    @(posedge clk);
    #1;
  endtask

  // One counted comparison.
  task automatic checkOutput(input string name, input logic [31:0] obs,
                             input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", name, obs, exp);
    end
  endtask

  initial begin
    int bndCb [4] = '{76, 77, 127, 128};
    int bndExp[4] = '{0, 1, 1, 0};
    int tagErr = 0;
    int ones   = 0;
    logic [7:0] cbv;

    rst = 1'b1; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = 8'd0;
    vsync = 1'b0; clken = 1'b0; valid = 1'b0; data = 24'd0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    checkOutput("rstMaskVsync", mask_vsync, 0);
    checkOutput("rstMaskValid", mask_valid, 0);
    checkOutput("rstMaskBit", mask_bit, 0);
    checkOutput("rstMaskXY", {mask_x, mask_y}, 0);
    checkOutput("rstFrameCnt", fcnt, 0);
    checkOutput("rstFrameDone", done, 0);
    checkOutput("rstFrameErr", err, 0);
    checkOutput("rstPending", cfg_pending, 0);
    rst = 1'b0;

    // Pixels before the first SOF are ignored
    applyStimulus(0, 1, 1, 8'd100, 8'd150);
    checkOutput("preSofIgnored", mask_valid, 0);

    // Frame 1 start
    applyStimulus(1, 0, 0, 8'd0, 8'd0);
    checkOutput("maskVsyncDelay", mask_vsync, 1);

    // Cb boundary inclusivity at Cr=150 with default window 77..127
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 1, 1, 8'(bndCb[k]), 8'd150);
      checkOutput("bndBit", mask_bit, bndExp[k]);
      checkOutput("bndX", mask_x, k);
    end

    // Rest of frame 1, with a cb_min write mid-frame that must not take effect
    for (int i = 4; i < H * V - 1; i++) begin
      if (i == 100) begin
        cfg_we = 1'b1; cfg_addr = 2'd0; cfg_wdata = 8'd200;
      end
      applyStimulus(0, 1, 1, 8'd100, 8'd150);
      cfg_we = 1'b0;
      if (i == 100) checkOutput("pendAfterWrite", cfg_pending, 1);
      if (mask_valid !== 1'b1 || mask_x !== 10'(i % H) ||
          mask_y !== 10'(i / H) || done !== 1'b0) tagErr++;
      if (mask_bit === 1'b1) ones++;
    end
    checkOutput("frame1TagSeq", tagErr, 0);
    checkOutput("frame1Ones", ones, 1195);

    // Last pixel closes the frame
    applyStimulus(0, 1, 1, 8'd100, 8'd150);
    checkOutput("lastX", mask_x, H - 1);
    checkOutput("lastY", mask_y, V - 1);
    checkOutput("closeDone", done, 1);
    checkOutput("closeErr", err, 0);
    checkOutput("closeCnt", fcnt, 1198);

    applyStimulus(0, 0, 0, 8'd0, 8'd0);
    checkOutput("donePulse", done, 0);
    checkOutput("cntHeld", fcnt, 1198);

    applyStimulus(0, 1, 1, 8'd100, 8'd150);
    checkOutput("waitSofIgnored", mask_valid, 0);

    // Frame 2: cb_min=200 committed, window inverted so nothing matches
    applyStimulus(1, 0, 0, 8'd0, 8'd0);
    checkOutput("pendCleared", cfg_pending, 0);
    applyStimulus(0, 1, 1, 8'd100, 8'd150);
    checkOutput("newCbMinValid", mask_valid, 1);
    checkOutput("newCbMinBit", mask_bit, 0);
    applyStimulus(0, 1, 1, 8'd127, 8'd150);
    checkOutput("minAboveMax", mask_bit, 0);

    // Restore cb_min in shadow, then write cb_max together with SOF
    cfg_we = 1'b1; cfg_addr = 2'd0; cfg_wdata = 8'd77;
    applyStimulus(0, 0, 0, 8'd0, 8'd0);
    cfg_we = 1'b0;
    checkOutput("pendSet", cfg_pending, 1);
    cfg_we = 1'b1; cfg_addr = 2'd1; cfg_wdata = 8'd90;
    applyStimulus(1, 0, 0, 8'd0, 8'd0);
    cfg_we = 1'b0;
    checkOutput("short2Done", done, 1);
    checkOutput("short2Err", err, 1);
    checkOutput("short2Cnt", fcnt, 0);
    checkOutput("pendKeptOnSofWrite", cfg_pending, 1);

    // Frame 3: window 77..127 (cb_max=90 not yet active)
    applyStimulus(0, 1, 1, 8'd100, 8'd150);
    checkOutput("oldShadowBit", mask_bit, 1);
    checkOutput("frame3FirstXY", {mask_x, mask_y}, 0);
    checkOutput("frame3DoneLow", done, 0);
    applyStimulus(0, 0, 1, 8'd100, 8'd150);
    checkOutput("clkenGated", mask_valid, 0);
    for (int j = 1; j < 1000; j++) begin
      cbv = (j < 300) ? 8'd100 : 8'd50;
      applyStimulus(0, 1, 1, cbv, 8'd150);
    end

    // Short frame after 1000 pixels, 300 of them skin
    applyStimulus(1, 0, 0, 8'd0, 8'd0);
    checkOutput("short3Done", done, 1);
    checkOutput("short3Err", err, 1);
    checkOutput("short3Cnt", fcnt, 300);
    checkOutput("pendClearedLate", cfg_pending, 0);
    applyStimulus(0, 1, 1, 8'd100, 8'd150);
    checkOutput("afterShortValid", mask_valid, 1);
    checkOutput("afterShortXY", {mask_x, mask_y}, 0);
    checkOutput("cbMax90Bit", mask_bit, 0);
    applyStimulus(0, 1, 1, 8'd80, 8'd150);
    checkOutput("cbMax90In", mask_bit, 1);
    checkOutput("afterShortX1", mask_x, 1);
    checkOutput("short3DonePulse", done, 0);

    // Asynchronous reset mid-frame
    rst = 1'b1;
    #1;
    checkOutput("midRstValid", mask_valid, 0);
    checkOutput("midRstX", mask_x, 0);
    checkOutput("midRstCnt", fcnt, 0);
    checkOutput("midRstErr", err, 0);
    checkOutput("midRstPending", cfg_pending, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(0, 1, 1, 8'd100, 8'd150);
    checkOutput("postRstIgnored", mask_valid, 0);

    // Clean frame after reset: default thresholds, count starts at 0
    applyStimulus(1, 0, 0, 8'd0, 8'd0);
    for (int p = 0; p < 5; p++) begin
      applyStimulus(0, 1, 1, 8'd120, 8'd150);
      if (p == 0) checkOutput("defaultsRestored", mask_bit, 1);
    end
    applyStimulus(1, 0, 0, 8'd0, 8'd0);
    checkOutput("postRstDone", done, 1);
    checkOutput("postRstCnt", fcnt, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
